// File: rtl/mem_stage_ctrl.sv
// Memory stage: branch resolution, req/ack data-memory access with timeout abort, MEM/WB register.
// Stalls upstream while an access is outstanding; a stalled edge writes a bubble into MEM/WB.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              isZeroBranch_in,
  input  logic              isUnconBranch_in,
  input  logic              memRead_in,
  input  logic              memwrite_in,
  input  logic              regwrite_in,
  input  logic              mem2reg_in,
  input  logic [DATA_W-1:0] shifted_PC_in,
  input  logic              alu_zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_mem_in,
  input  logic [REG_W-1:0]  write_reg_in,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_fault,
  output logic              regwrite_out,
  output logic              mem2reg_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_W-1:0]  write_reg_out
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_d, we_d, fault_d;
  logic [DATA_W-1:0] addr_d, wdata_d;
  logic              wb_regwrite_d, wb_mem2reg_d;
  logic [DATA_W-1:0] wb_rdata_d, wb_alu_d;
  logic [REG_W-1:0]  wb_reg_d;
  logic              access;

  assign access        = memRead_in | memwrite_in;
  assign pc_src        = isUnconBranch_in | (isZeroBranch_in & alu_zero_in);
  assign branch_target = shifted_PC_in;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = dmem_req;
    we_d          = dmem_we;
    addr_d        = dmem_addr;
    wdata_d       = dmem_wdata;
    fault_d       = 1'b0;
    stall         = 1'b0;
    wb_regwrite_d = regwrite_in;
    wb_mem2reg_d  = mem2reg_in;
    wb_reg_d      = write_reg_in;
    wb_alu_d      = alu_result_in;
    wb_rdata_d    = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall         = 1'b1;
          addr_d        = alu_result_in;
          wdata_d       = write_data_mem_in;
          we_d          = memwrite_in & ~memRead_in;
          req_d         = 1'b1;
          cnt_d         = '0;
          wb_regwrite_d = 1'b0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        // An ack in the final allowed cycle beats the timeout.
        if (dmem_ack) begin
          req_d      = 1'b0;
          wb_rdata_d = dmem_rdata;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d         = 1'b0;
          fault_d       = 1'b1;
          wb_regwrite_d = 1'b0;
          state_d       = IDLE;
        end else begin
          stall         = 1'b1;
          cnt_d         = cnt_q + 1'b1;
          wb_regwrite_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      mem_fault      <= 1'b0;
      regwrite_out   <= 1'b0;
      mem2reg_out    <= 1'b0;
      read_data_out  <= '0;
      alu_result_out <= '0;
      write_reg_out  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dmem_req       <= req_d;
      dmem_we        <= we_d;
      dmem_addr      <= addr_d;
      dmem_wdata     <= wdata_d;
      mem_fault      <= fault_d;
      regwrite_out   <= wb_regwrite_d;
      mem2reg_out    <= wb_mem2reg_d;
      read_data_out  <= wb_rdata_d;
      alu_result_out <= wb_alu_d;
      write_reg_out  <= wb_reg_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed and random instructions, memory responder, MEM/WB scoreboard.
module tb_mem_stage_ctrl;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic zb, ub, mrd, mwr, rwi, m2ri, azi;
  logic [DW-1:0] spc, alu, wdat, rdat;
  logic [RW-1:0] wreg;
  logic ack;
  logic pc_src, stall, dmem_req, dmem_we, mem_fault, regwrite_out, mem2reg_out;
  logic [DW-1:0] branch_target, dmem_addr, dmem_wdata, read_data_out, alu_result_out;
  logic [RW-1:0] write_reg_out;

  mem_stage_ctrl #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .isZeroBranch_in(zb), .isUnconBranch_in(ub),
    .memRead_in(mrd), .memwrite_in(mwr), .regwrite_in(rwi), .mem2reg_in(m2ri),
    .shifted_PC_in(spc), .alu_zero_in(azi), .alu_result_in(alu),
    .write_data_mem_in(wdat), .write_reg_in(wreg),
    .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(ack), .dmem_rdata(rdat), .mem_fault(mem_fault),
    .regwrite_out(regwrite_out), .mem2reg_out(mem2reg_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out)
  );

  typedef struct {
    logic          regwrite;
    logic          mem2reg;
    logic [RW-1:0] wreg;
    logic [DW-1:0] alu;
    logic [DW-1:0] rdata;
    logic          chk_rd;
    logic          fault;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic active   = 1'b0;
  logic mon_pending = 1'b0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Writeback monitor: the edge after a non-stalled cycle retires one instruction.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_pending) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("wb_regwrite", regwrite_out, mon_e.regwrite);
          chk("wb_mem2reg", mem2reg_out, mon_e.mem2reg);
          chk("wb_write_reg", write_reg_out, mon_e.wreg);
          chk("wb_alu_result", alu_result_out, mon_e.alu);
          if (mon_e.chk_rd) chk("wb_read_data", read_data_out, mon_e.rdata);
          chk("mem_fault", mem_fault, mon_e.fault);
        end
      end else if (active) begin
        chk("mem_fault_quiet", mem_fault, 1'b0);
      end
      mon_pending = active && !reset && !stall;
    end
  end

  // One instruction: drive EX/MEM, act as memory with ack after d BUSY cycles (d>=TMO: never).
  task automatic issue(input logic i_zb, i_ub, i_rd, i_wr, i_rw, i_m2r, i_az,
                       input logic [DW-1:0] i_spc, i_alu, i_wd,
                       input logic [RW-1:0] i_wreg, input int d, input logic [DW-1:0] i_rdat);
    exp_t e;
    logic acc;
    int   exp_stall, nst, b;
    logic done;
    acc = i_rd | i_wr;
    zb = i_zb; ub = i_ub; mrd = i_rd; mwr = i_wr; rwi = i_rw; m2ri = i_m2r; azi = i_az;
    spc = i_spc; alu = i_alu; wdat = i_wd; wreg = i_wreg;
    ack = 1'($urandom_range(0, 1));
    rdat = $urandom;
    e.regwrite = (acc && d >= TMO) ? 1'b0 : i_rw;
    e.mem2reg  = i_m2r;
    e.wreg     = i_wreg;
    e.alu      = i_alu;
    e.rdata    = acc ? i_rdat : '0;
    e.chk_rd   = !(acc && d >= TMO);
    e.fault    = acc && d >= TMO;
    exp_stall  = !acc ? 0 : ((d < TMO) ? d + 1 : TMO);
    sb.push_back(e);
    @(negedge clk);
    chk("pc_src", pc_src, i_ub | (i_zb & i_az));
    chk("branch_target", branch_target, i_spc);
    nst = stall ? 1 : 0;
    if (stall) begin
      b = 0;
      done = 1'b0;
      while (!done) begin
        @(posedge clk); #1;
        ack  = (b == d);
        rdat = (b == d) ? i_rdat : $urandom;
        chk("dmem_req_busy", dmem_req, 1'b1);
        chk("dmem_addr", dmem_addr, i_alu);
        chk("dmem_we", dmem_we, i_wr & ~i_rd);
        chk("dmem_wdata", dmem_wdata, i_wd);
        @(negedge clk);
        if (stall) nst++;
        else done = 1'b1;
        b++;
        if (!done && b > TMO + 2) begin
          chk("busy_budget", 32'(b), 32'(TMO));
          done = 1'b1;
        end
      end
    end
    chk("stall_cycles", 32'(nst), 32'(exp_stall));
    @(posedge clk); #1;
    ack = 1'b0;
    if (acc) chk("dmem_req_after", dmem_req, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, w;
    int   d;
    reset = 1'b1;
    zb = 0; ub = 0; mrd = 0; mwr = 0; rwi = 0; m2ri = 0; azi = 0;
    spc = '0; alu = '0; wdat = '0; wreg = '0; ack = 0; rdat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_dmem_addr", dmem_addr, '0);
    chk("rst_dmem_wdata", dmem_wdata, '0);
    chk("rst_mem_fault", mem_fault, 1'b0);
    chk("rst_regwrite", regwrite_out, 1'b0);
    chk("rst_mem2reg", mem2reg_out, 1'b0);
    chk("rst_read_data", read_data_out, '0);
    chk("rst_alu_result", alu_result_out, '0);
    chk("rst_write_reg", write_reg_out, '0);
    chk("rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset  = 1'b0;
    active = 1'b1;

    issue(0, 0, 0, 0, 1, 0, 0, '0, 32'h42, '0, 5'd3, 0, '0);
    issue(0, 0, 1, 0, 1, 1, 0, '0, 32'h100, '0, 5'd7, 3, 32'hDEADBEEF);
    issue(0, 0, 0, 1, 0, 0, 0, '0, 32'h200, 32'hCAFEF00D, 5'd0, 0, '0);
    issue(0, 0, 1, 0, 1, 1, 0, '0, 32'h300, '0, 5'd9, 99, '0);
    issue(0, 0, 1, 0, 1, 1, 0, '0, 32'h304, '0, 5'd10, TMO - 1, 32'h12345678);
    issue(0, 0, 1, 1, 1, 1, 0, '0, 32'h308, 32'h55AA55AA, 5'd11, 1, 32'h0BADF00D);
    issue(1, 0, 0, 0, 0, 0, 0, 32'h40, 32'h1, '0, 5'd0, 0, '0);
    issue(1, 0, 0, 0, 0, 0, 1, 32'h40, 32'h0, '0, 5'd0, 0, '0);
    issue(0, 1, 0, 0, 0, 0, 0, 32'h80, 32'h7, '0, 5'd0, 0, '0);
    issue(0, 1, 0, 0, 0, 0, 1, 32'h84, 32'h0, '0, 5'd0, 0, '0);

    for (int i = 0; i < 150; i++) begin
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 2, TMO + 3)) : int'($urandom_range(0, 5));
      issue(1'($urandom), 1'($urandom), r, w, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, 5'($urandom), d, $urandom);
    end

    active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of an access, then a stray ack.
    mrd = 1; mwr = 0; rwi = 1; m2ri = 1; alu = 32'h400; ack = 0;
    zb = 0; ub = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midbusy_req", dmem_req, 1'b1);
    chk("midbusy_stall", stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mrd = 0; rwi = 0;
    @(negedge clk);
    chk("postrst_req", dmem_req, 1'b0);
    chk("postrst_regwrite", regwrite_out, 1'b0);
    chk("postrst_stall", stall, 1'b0);
    @(posedge clk); #1;
    ack  = 1'b1;
    rdat = 32'hFEEDFACE;
    @(posedge clk); #1;
    ack = 1'b0;
    @(negedge clk);
    chk("late_ack_regwrite", regwrite_out, 1'b0);
    chk("late_ack_read_data", read_data_out, '0);
    chk("late_ack_fault", mem_fault, 1'b0);
    chk("late_ack_req", dmem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage consumer of the EX/MEM pipeline register outputs. It resolves branches, runs variable-latency data-memory accesses over a req/ack handshake with a timeout, and stalls upstream stages while an access is outstanding. It also owns the MEM/WB pipeline register that feeds writeback.

Parameters:
DATA_W, 32, data/address/PC width
REG_W, 5, destination register index width
TIMEOUT, 15, max BUSY cycles without ack before abort (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
isZeroBranch_in  in  1  conditional branch (CBZ-style)
isUnconBranch_in  in  1  unconditional branch
memRead_in  in  1  load
memwrite_in  in  1  store
regwrite_in  in  1  writeback enable
mem2reg_in  in  1  WB selects memory data
shifted_PC_in  in  DATA_W  branch target
alu_zero_in  in  1  ALU zero flag
alu_result_in  in  DATA_W  memory address / ALU result
write_data_mem_in  in  DATA_W  store data
write_reg_in  in  REG_W  destination register
pc_src  out  1  branch taken (combinational)
branch_target  out  DATA_W  = shifted_PC_in (combinational)
stall  out  1  freeze IF/ID/EX and EX/MEM (combinational)
dmem_req  out  1  memory request (registered)
dmem_we  out  1  1=write (registered)
dmem_addr  out  DATA_W  registered
dmem_wdata  out  DATA_W  registered
dmem_ack  in  1  memory done; rdata valid same cycle
dmem_rdata  in  DATA_W  read data
mem_fault  out  1  one-cycle pulse on timeout abort
regwrite_out, mem2reg_out  out  1  MEM/WB
read_data_out, alu_result_out  out  DATA_W  MEM/WB
write_reg_out  out  REG_W  MEM/WB

Behaviour:
- Reset: state IDLE, timeout counter 0. All registered outputs 0: dmem_*, mem_fault, and all MEM/WB outputs.
- pc_src = isUnconBranch_in | (isZeroBranch_in & alu_zero_in). Purely combinational, independent of state.
- access = memRead_in | memwrite_in. If both are set, treat it as a read (dmem_we=0).
- States: IDLE and BUSY.
- IDLE with no access:
  - stall=0.
  - MEM/WB captures the inputs at the edge: read_data_out <= 0, others pass through.
  - Latency is 1 cycle.
- IDLE with access:
  - stall=1.
  - At the edge, latch dmem_addr <= alu_result_in, dmem_wdata <= write_data_mem_in, dmem_we <= memwrite_in & ~memRead_in.
  - Set dmem_req <= 1 and counter <= 0, then go to BUSY.
  - MEM/WB takes a bubble (regwrite_out <= 0).
- BUSY without ack:
  - stall=1, dmem_req held at 1, counter increments, MEM/WB bubble.
  - The upstream EX/MEM inputs are held stable by the stall.
- BUSY with dmem_ack:
  - stall=0 in this cycle.
  - At the edge: dmem_req <= 0; MEM/WB captures the inputs with read_data_out <= dmem_rdata; go to IDLE.
  - Upstream advances on the same edge.
  - Zero-wait memory (ack in the first BUSY cycle) gives a 2-cycle instruction.
- Timeout: in BUSY, when the counter equals TIMEOUT-1 and there is no ack:
  - stall=0 in this cycle.
  - At the edge: dmem_req <= 0, mem_fault <= 1 for 1 cycle, MEM/WB captured with regwrite_out <= 0, go to IDLE.
  - If ack arrives in the same cycle, ack wins and there is no fault.
- dmem_ack in IDLE is ignored.
- dmem_addr, dmem_wdata and dmem_we stay constant for the whole BUSY period.
- Reset mid-BUSY: dmem_req is 0 after that edge, there is no writeback, and a late ack is then ignored.
- Every edge with stall=1 writes a bubble into MEM/WB. The remaining MEM/WB fields are don't-care but must be deterministic: they load the inputs.

Test Plan:
- Reset: assert reset for 2 cycles mid-BUSY -> dmem_req=0, regwrite_out=0, state IDLE; an ack on the following cycle produces no writeback.
- ALU op (regwrite_in=1, alu_result_in=0x0000_0042, write_reg_in=3, no mem) -> next cycle regwrite_out=1, alu_result_out=0x42, write_reg_out=3, stall never 1.
- Load at 0x100, ack 3 cycles after dmem_req rises with rdata 0xDEADBEEF:
  - stall high for 4 cycles and low in the ack cycle.
  - Next cycle read_data_out=0xDEADBEEF, mem2reg_out=1.
  - dmem_addr=0x100 and dmem_we=0 throughout.
- Store 0xCAFEF00D at 0x200, zero-wait ack -> dmem_we=1, dmem_wdata=0xCAFEF00D, req high exactly 1 cycle, stall high exactly 1 cycle.
- Timeout with TIMEOUT=15 and ack never asserted -> req drops after 15 BUSY cycles, mem_fault=1 for exactly 1 cycle, regwrite_out=0; ack in the 15th cycle -> no fault, normal writeback.
- Branches:
  - isZeroBranch_in=1 with alu_zero_in=0 -> pc_src=0.
  - isZeroBranch_in=1 with alu_zero_in=1 -> pc_src=1, branch_target=shifted_PC_in=0x40.
  - isUnconBranch_in=1 -> pc_src=1 regardless of alu_zero_in.
